// File: rtl/risc_v_32_imem_resp_if.sv
// risc_v_32_imem_resp_if
//   Fetch bus between the IF stage (master) and the instruction-memory
//   responder (slave).
//   req_valid/req_ready/req_addr   : fetch request handshake, byte address (PC)
//   resp_valid/resp_ready          : response handshake
//   resp_inst/resp_addr/resp_err   : returned word, its byte address, fault flag
interface risc_v_32_imem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic [31:0] resp_addr;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_inst, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_inst, resp_addr, resp_err
  );
endinterface

// File: rtl/risc_v_32_imem_resp.sv
// risc_v_32_imem_resp
//   Instruction-memory responder for the RV32I fetch path. Fetch requests are
//   accepted over a valid/ready handshake, the word is read from RAM at accept
//   and carried down a fixed LATENCY-deep pipeline; responses leave in order
//   with backpressure. flush drops everything in flight. A write port preloads
//   the RAM (read-before-write against a same-cycle fetch).
//   Ports:
//     clk, clrn              clock, asynchronous active-low reset
//     bus (slave modport)    request/response handshake signals
//     flush                  discard all in-flight requests
//     wr_en/wr_addr/wr_data  preload write port (word index)
//   Parameters: DEPTH_LOG2 (RAM depth in words, log2), LATENCY (1..4)
//   Optional macro IMEM_ERR_EN: flag misaligned / out-of-range fetches with
//   resp_err=1 and return a NOP instead of RAM data.
module risc_v_32_imem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  risc_v_32_imem_resp_if.slave  bus,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data
);

  localparam int          LAST = LATENCY - 1;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] err_q,   err_d;
  logic [31:0]        addr_q [LATENCY];
  logic [31:0]        addr_d [LATENCY];
  logic [31:0]        inst_q [LATENCY];
  logic [31:0]        inst_d [LATENCY];

  logic                  stall;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           ram_rdata;
  logic [31:0]           fetch_inst;
  logic                  fetch_err;

  assign stall  = valid_q[LAST] & ~bus.resp_ready;
  assign accept = bus.req_valid & bus.req_ready;

  assign bus.req_ready  = ~stall & ~flush;
  assign bus.resp_valid = valid_q[LAST];
  assign bus.resp_inst  = inst_q[LAST];
  assign bus.resp_addr  = addr_q[LAST];
  assign bus.resp_err   = err_q[LAST];

  // Asynchronous read sampled into stage 0 at the accept edge; the write
  // lands on that same edge, so a colliding fetch sees the old word.
  assign rd_idx    = bus.req_addr[DEPTH_LOG2+1:2];
  assign ram_rdata = mem[rd_idx];

`ifdef IMEM_ERR_EN
  assign fetch_err  = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[31:DEPTH_LOG2+2] != '0);
  assign fetch_inst = fetch_err ? NOP : ram_rdata;
`else
  // Low byte-offset bits and upper bits are don't-care; the index wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:DEPTH_LOG2+2], bus.req_addr[1:0], NOP};
  assign fetch_err  = 1'b0;
  assign fetch_inst = ram_rdata;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Valid bits always shift; payload only moves behind a valid entry so the
  // response outputs keep their last values across bubbles and flushes.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d[0] = accept;
      if (accept) begin
        addr_d[0] = bus.req_addr;
        inst_d[0] = fetch_inst;
        err_d[0]  = fetch_err;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          addr_d[i] = addr_q[i-1];
          inst_d[i] = inst_q[i-1];
          err_d[i]  = err_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= addr_d[i];
        inst_q[i] <= inst_d[i];
      end
    end
  end

endmodule

// File: tb/tb_risc_v_32_imem_resp.sv
// tb_risc_v_32_imem_resp
//   Directed cycle-by-cycle vectors for the instruction-memory responder
//   (DEPTH_LOG2=10, LATENCY=2). Each vector drives one cycle of inputs and
//   checks req_ready / resp_* against hand-computed values.
module tb_risc_v_32_imem_resp;

  logic        clk;
  logic        clrn;
  logic        flush;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  risc_v_32_imem_resp_if bus ();

  risc_v_32_imem_resp #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .bus     (bus.slave),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [9:0] idx, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = idx;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // One cycle: drive inputs, let combinational outputs settle, check, advance.
  task automatic vec(input string tag, input logic rv, input logic [31:0] addr,
                     input logic rr, input logic fl, input logic erdy, input logic evld,
                     input logic [31:0] einst, input logic [31:0] eaddr,
                     input logic eerr, input logic ci);
    bus.req_valid  = rv;
    bus.req_addr   = addr;
    bus.resp_ready = rr;
    flush          = fl;
    #1;
    chk({tag, ".rdy"}, {31'd0, bus.req_ready}, {31'd0, erdy});
    chk({tag, ".vld"}, {31'd0, bus.resp_valid}, {31'd0, evld});
    if (ci) begin
      chk({tag, ".inst"}, bus.resp_inst, einst);
      chk({tag, ".addr"}, bus.resp_addr, eaddr);
      chk({tag, ".err"},  {31'd0, bus.resp_err}, {31'd0, eerr});
    end
    tick();
  endtask

  initial begin
    clrn           = 1'b0;
    flush          = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b1;

    #12;
    chk("rst.vld",  {31'd0, bus.resp_valid}, 32'd0);
    chk("rst.inst", bus.resp_inst, 32'd0);
    chk("rst.addr", bus.resp_addr, 32'd0);
    chk("rst.err",  {31'd0, bus.resp_err}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) wr_word(10'(i), 32'hA0 + 32'(i));

    // back-to-back stream, no backpressure
    vec("t1c0", 1, 32'h0, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
    vec("t1c1", 1, 32'h4, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
    vec("t1c2", 1, 32'h8, 1, 0, 1, 1, 32'hA0, 32'h0, 0, 1);
    vec("t1c3", 1, 32'hC, 1, 0, 1, 1, 32'hA1, 32'h4, 0, 1);
    vec("t1c4", 0, 32'h0, 1, 0, 1, 1, 32'hA2, 32'h8, 0, 1);
    vec("t1c5", 0, 32'h0, 1, 0, 1, 1, 32'hA3, 32'hC, 0, 1);
    vec("t1c6", 0, 32'h0, 1, 0, 1, 0, 32'hA3, 32'hC, 0, 1);

    // backpressure holds A0 for three cycles, nothing lost or duplicated
    vec("t2c0", 1, 32'h0, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
    vec("t2c1", 1, 32'h4, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
    vec("t2c2", 1, 32'h8, 0, 0, 0, 1, 32'hA0, 32'h0, 0, 1);
    vec("t2c3", 1, 32'h8, 0, 0, 0, 1, 32'hA0, 32'h0, 0, 1);
    vec("t2c4", 1, 32'h8, 0, 0, 0, 1, 32'hA0, 32'h0, 0, 1);
    vec("t2c5", 1, 32'h8, 1, 0, 1, 1, 32'hA0, 32'h0, 0, 1);
    vec("t2c6", 1, 32'hC, 1, 0, 1, 1, 32'hA1, 32'h4, 0, 1);
    vec("t2c7", 0, 32'h0, 1, 0, 1, 1, 32'hA2, 32'h8, 0, 1);
    vec("t2c8", 0, 32'h0, 1, 0, 1, 1, 32'hA3, 32'hC, 0, 1);
    vec("t2c9", 0, 32'h0, 1, 0, 1, 0, 32'hA3, 32'hC, 0, 1);

    // flush while stalled drops both in-flight requests; flush blocks accept
    vec("t3c0", 1, 32'h0, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
    vec("t3c1", 1, 32'h4, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
    vec("t3c2", 1, 32'h8, 0, 1, 0, 1, 32'hA0, 32'h0, 0, 1);
    vec("t3c3", 1, 32'h8, 1, 0, 1, 0, 32'hA0, 32'h0, 0, 1);
    vec("t3c4", 0, 32'h0, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
    vec("t3c5", 0, 32'h0, 1, 0, 1, 1, 32'hA2, 32'h8, 0, 1);
    vec("t3c6", 0, 32'h0, 1, 0, 1, 0, 32'hA2, 32'h8, 0, 1);
    vec("t3c7", 1, 32'h0, 1, 1, 0, 0, 32'h0,  32'h0, 0, 0);
    vec("t3c8", 0, 32'h0, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
    vec("t3c9", 0, 32'h0, 1, 0, 1, 0, 32'hA2, 32'h8, 0, 1);

    // same-cycle write and fetch of word 1: old data first, new data next
    wr_en   = 1'b1;
    wr_addr = 10'd1;
    wr_data = 32'hBEEF;
    vec("t4c0", 1, 32'h4, 1, 0, 1, 0, 32'h0,    32'h0, 0, 0);
    wr_en   = 1'b0;
    vec("t4c1", 1, 32'h4, 1, 0, 1, 0, 32'h0,    32'h0, 0, 0);
    vec("t4c2", 0, 32'h0, 1, 0, 1, 1, 32'hA1,   32'h4, 0, 1);
    vec("t4c3", 0, 32'h0, 1, 0, 1, 1, 32'hBEEF, 32'h4, 0, 1);
    vec("t4c4", 0, 32'h0, 1, 0, 1, 0, 32'hBEEF, 32'h4, 0, 1);
    wr_word(10'd1, 32'hA1);

`ifdef IMEM_ERR_EN
    vec("t5c0", 1, 32'h2,    1, 0, 1, 0, 32'h0,  32'h0,    0, 0);
    vec("t5c1", 1, 32'h1000, 1, 0, 1, 0, 32'h0,  32'h0,    0, 0);
    vec("t5c2", 1, 32'h4,    1, 0, 1, 1, 32'h13, 32'h2,    1, 1);
    vec("t5c3", 0, 32'h0,    1, 0, 1, 1, 32'h13, 32'h1000, 1, 1);
    vec("t5c4", 0, 32'h0,    1, 0, 1, 1, 32'hA1, 32'h4,    0, 1);
    vec("t5c5", 0, 32'h0,    1, 0, 1, 0, 32'hA1, 32'h4,    0, 1);
`else
    vec("t5c0", 1, 32'h1004, 1, 0, 1, 0, 32'h0,  32'h0,    0, 0);
    vec("t5c1", 1, 32'h2,    1, 0, 1, 0, 32'h0,  32'h0,    0, 0);
    vec("t5c2", 1, 32'h4,    1, 0, 1, 1, 32'hA1, 32'h1004, 0, 1);
    vec("t5c3", 0, 32'h0,    1, 0, 1, 1, 32'hA0, 32'h2,    0, 1);
    vec("t5c4", 0, 32'h0,    1, 0, 1, 1, 32'hA1, 32'h4,    0, 1);
    vec("t5c5", 0, 32'h0,    1, 0, 1, 0, 32'hA1, 32'h4,    0, 1);
`endif

    // async reset with two in flight and a stalled response showing
    vec("t6c0", 1, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
    vec("t6c1", 1, 32'h4, 1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h8;
    bus.resp_ready = 1'b0;
    #1;
    chk("t6.pre_vld",  {31'd0, bus.resp_valid}, 32'd1);
    chk("t6.pre_inst", bus.resp_inst, 32'hA0);
    clrn = 1'b0;
    #1;
    chk("t6.rst_vld",  {31'd0, bus.resp_valid}, 32'd0);
    chk("t6.rst_inst", bus.resp_inst, 32'd0);
    chk("t6.rst_addr", bus.resp_addr, 32'd0);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    tick();
    vec("t6c3", 0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0, 1);
    vec("t6c4", 0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0, 1);
    vec("t6c5", 0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
